ad7771_frame_averager: RTL

- Downstream consumer of the AD7771 DOUT reader. Takes each completed 64-bit DOUT frame and checks both 8-bit channel headers.
- Discards bad frames and boxcar-averages 2^LOG2_AVG good samples per channel. Emits one averaged pair per block.
- Feeds the lock-in / logging stages at a reduced rate: 128 kS/s / 2^LOG2_AVG.

---
 rtl/ad7771_pkg.sv | 36 +++
 rtl/ad7771_chan_accumulator.sv | 45 ++++
 rtl/ad7771_frame_averager.sv | 112 +++++++++++
 3 files changed

// File: rtl/ad7771_pkg.sv
// Shared AD7771 DOUT frame layout: header fields, frame slices and the frame struct.
// The header check helper lives here so every consumer of the frame agrees on it.
package ad7771_pkg;

  localparam int DATA_W  = 24;
  localparam int HDR_W   = 8;
  localparam int FRAME_W = 64;
  localparam int ERR_W   = 16;

  localparam int HDR_ERR_BIT = 7;
  localparam int HDR_ID_MSB  = 6;
  localparam int HDR_ID_LSB  = 4;

  localparam int CH1_HDR_MSB  = 63;
  localparam int CH1_HDR_LSB  = 56;
  localparam int CH1_DATA_MSB = 55;
  localparam int CH1_DATA_LSB = 32;
  localparam int CH2_HDR_MSB  = 31;
  localparam int CH2_HDR_LSB  = 24;
  localparam int CH2_DATA_MSB = 23;
  localparam int CH2_DATA_LSB = 0;

  typedef struct packed {
    logic [HDR_W-1:0]  ch1_hdr;
    logic [DATA_W-1:0] ch1_data;
    logic [HDR_W-1:0]  ch2_hdr;
    logic [DATA_W-1:0] ch2_data;
  } ad7771_frame_t;

  // Takes only the error flag and ID bits; the low nibble of a header carries nothing we use.
  function automatic logic hdr_ok(input logic [HDR_ERR_BIT:HDR_ID_LSB] hdr_hi,
                                  input logic [HDR_ID_MSB-HDR_ID_LSB:0] id);
    return !hdr_hi[HDR_ERR_BIT] && (hdr_hi[HDR_ID_MSB:HDR_ID_LSB] == id);
  endfunction

endpackage

// File: rtl/ad7771_chan_accumulator.sv
// One channel of the boxcar averager: accumulates sign-extended samples and, on the
// closing sample of a block, registers the floor-shifted mean.
module ad7771_chan_accumulator
  import ad7771_pkg::*;
#(
  parameter int LOG2_AVG = 4,
  parameter int ACC_W    = DATA_W + LOG2_AVG
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic signed [ACC_W-1:0]  sample,
  input  logic                     add_en,
  input  logic                     clear,
  input  logic                     done,
  output logic signed [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] sum_p0;

  // Arithmetic shift floors toward -inf; the block sum always fits back in DATA_W.
  function automatic logic signed [DATA_W-1:0] floor_mean(input logic signed [ACC_W-1:0] s);
    return DATA_W'(s >>> LOG2_AVG);
  endfunction

  assign sum_p0 = acc_p0 + sample;

  // p0 -> p1: accumulator update and averaged-result register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_p0 <= '0;
      result <= '0;
    end else if (clear) begin
      acc_p0 <= '0;
    end else if (add_en) begin
      if (done) begin
        acc_p0 <= '0;
        result <= floor_mean(sum_p0);
      end else begin
        acc_p0 <= sum_p0;
      end
    end
  end

endmodule

// File: rtl/ad7771_frame_averager.sv
// Validates AD7771 DOUT frame headers, drops bad frames and boxcar-averages 2^LOG2_AVG
// good samples per channel into one averaged pair per block.
module ad7771_frame_averager
  import ad7771_pkg::*;
#(
  parameter int         LOG2_AVG = 4,
  parameter logic [2:0] CH1_ID   = 3'd0,
  parameter logic [2:0] CH2_ID   = 3'd1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_valid_i,
  input  logic [FRAME_W-1:0]       frame_i,
  input  logic                     clear_i,
  output logic signed [DATA_W-1:0] avg_ch1_o,
  output logic signed [DATA_W-1:0] avg_ch2_o,
  output logic                     avg_valid_o,
  output logic                     frame_err_o,
  output logic [ERR_W-1:0]         err_count_o
);

  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG == 0) ? 1 : LOG2_AVG;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  ad7771_frame_t           frame_p0;
  logic                    accept_p0;
  logic                    hdr_good_p0;
  logic                    good_p0;
  logic                    bad_p0;
  logic                    done_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic signed [ACC_W-1:0] ch1_ext_p0;
  logic signed [ACC_W-1:0] ch2_ext_p0;
  logic                    vld_p1;
  logic                    err_p1;
  logic [ERR_W-1:0]        err_cnt_p1;
  logic                    unused_hdr_lsbs;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] d);
    return ACC_W'(d);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == {ERR_W{1'b1}}) ? c : c + ERR_W'(1);
  endfunction

  assign frame_p0 = ad7771_frame_t'(frame_i);
  assign unused_hdr_lsbs = ^{frame_p0.ch1_hdr[HDR_ID_LSB-1:0], frame_p0.ch2_hdr[HDR_ID_LSB-1:0]};

  // A coincident clear swallows the frame entirely: neither accumulated nor counted as an error.
  assign hdr_good_p0 = hdr_ok(frame_p0.ch1_hdr[HDR_ERR_BIT:HDR_ID_LSB], CH1_ID) &&
                       hdr_ok(frame_p0.ch2_hdr[HDR_ERR_BIT:HDR_ID_LSB], CH2_ID);
  assign accept_p0   = frame_valid_i && !clear_i;
  assign good_p0     = accept_p0 && hdr_good_p0;
  assign bad_p0      = accept_p0 && !hdr_good_p0;
  assign done_p0     = (cnt_p0 == CNT_LAST);
  assign ch1_ext_p0  = sext(frame_p0.ch1_data);
  assign ch2_ext_p0  = sext(frame_p0.ch2_data);

  // p0 -> p1: sample counter, strobes and rejected-frame count
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_p0     <= '0;
      vld_p1     <= 1'b0;
      err_p1     <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      vld_p1 <= good_p0 && done_p0;
      err_p1 <= bad_p0;
      if (bad_p0) begin
        err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
      if (clear_i) begin
        cnt_p0 <= '0;
      end else if (good_p0) begin
        cnt_p0 <= done_p0 ? '0 : cnt_p0 + CNT_W'(1);
      end
    end
  end

  ad7771_chan_accumulator #(
    .LOG2_AVG (LOG2_AVG),
    .ACC_W    (ACC_W)
  ) u_acc_ch1 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sample  (ch1_ext_p0),
    .add_en  (good_p0),
    .clear   (clear_i),
    .done    (done_p0),
    .result  (avg_ch1_o)
  );

  ad7771_chan_accumulator #(
    .LOG2_AVG (LOG2_AVG),
    .ACC_W    (ACC_W)
  ) u_acc_ch2 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sample  (ch2_ext_p0),
    .add_en  (good_p0),
    .clear   (clear_i),
    .done    (done_p0),
    .result  (avg_ch2_o)
  );

  assign avg_valid_o = vld_p1;
  assign frame_err_o = err_p1;
  assign err_count_o = err_cnt_p1;

endmodule
